// File: rtl/btn_pkg.sv
// btn_pkg: FSM state encoding and default timing constants for the button pulse generator
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        PULSE    = 3'd2,
        HELD     = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    localparam int DB_CYCLES_DEF     = 4;
    localparam int REPEAT_CYCLES_DEF = 8;
    localparam int CW_DEF            = 4;

endpackage

// File: rtl/btn_cnt_pulse_sync2.sv
// sync2: two-flop synchronizer with synchronous active-high reset to 0
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    // shift the raw level through two flops; only the second flop is used downstream
    always_ff @(posedge clock) begin
        ff_q <= reset ? 2'b00 : {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/btn_cnt_pulse.sv
// btn_cnt_pulse: debounced push-button to single-cycle count pulse; BTN_AUTO_REPEAT_EN adds auto-repeat while held
module btn_cnt_pulse
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
`ifdef BTN_AUTO_REPEAT_EN
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
`endif
    parameter int CW            = CW_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic cnt,
    output logic level,
    output logic busy
);

    logic          btn_s;
    state_t        state_q, state_d;
    logic [CW-1:0] dbc_q, dbc_d;
    logic          db_done;
    logic          cnt_q, level_q, busy_q;
`ifdef BTN_AUTO_REPEAT_EN
    logic [CW-1:0] rpc_q, rpc_d;
    logic          rp_done;
    assign rp_done = rpc_q == CW'(REPEAT_CYCLES - 1);
`endif

    sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (btn),
        .q_o   (btn_s)
    );

    assign db_done = dbc_q == CW'(DB_CYCLES - 1);

    // next state and counters; every state entry clears the counter it uses
    always_comb begin
        state_d = IDLE;
        dbc_d   = dbc_q;
`ifdef BTN_AUTO_REPEAT_EN
        rpc_d   = rpc_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = btn_s ? PRESS_DB : IDLE;
                dbc_d   = btn_s ? '0 : dbc_q;
            end
            PRESS_DB: begin
                state_d = !btn_s ? IDLE : db_done ? PULSE : PRESS_DB;
                dbc_d   = (btn_s && !db_done) ? dbc_q + CW'(1) : dbc_q;
            end
            PULSE: begin
                state_d = HELD;
`ifdef BTN_AUTO_REPEAT_EN
                rpc_d   = '0;
`endif
            end
            HELD: begin
`ifdef BTN_AUTO_REPEAT_EN
                state_d = !btn_s ? REL_DB : rp_done ? PULSE : HELD;
                rpc_d   = btn_s ? rpc_q + CW'(1) : rpc_q;
`else
                state_d = btn_s ? HELD : REL_DB;
`endif
                dbc_d   = btn_s ? dbc_q : '0;
            end
            REL_DB: begin
                state_d = btn_s ? HELD : db_done ? IDLE : REL_DB;
                dbc_d   = (!btn_s && !db_done) ? dbc_q + CW'(1) : dbc_q;
`ifdef BTN_AUTO_REPEAT_EN
                rpc_d   = btn_s ? '0 : rpc_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counters and Moore outputs registered from the next state so they align with the state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dbc_q   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            rpc_q   <= '0;
`endif
            cnt_q   <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dbc_q   <= dbc_d;
`ifdef BTN_AUTO_REPEAT_EN
            rpc_q   <= rpc_d;
`endif
            cnt_q   <= state_d == PULSE;
            level_q <= state_d inside {PULSE, HELD, REL_DB};
            busy_q  <= state_d inside {PRESS_DB, REL_DB};
        end
    end

    assign cnt   = cnt_q;
    assign level = level_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_btn_cnt_pulse.sv
// tb_btn_cnt_pulse: scoreboard bench for btn_cnt_pulse; expected pulse cycles queued at stimulus, popped on cnt
module tb_btn_cnt_pulse;
    import btn_pkg::*;

    localparam int DB = DB_CYCLES_DEF;
    localparam int RP = REPEAT_CYCLES_DEF;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int N_REP = 6;
`else
    localparam int N_REP = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn   = 1'b0;
    logic cnt, level, busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic prev_cnt = 1'b0;
    int ctr4 = 0;
    int co_cnt = 0;
    int co_at = 0;
    int pulse_n = 0;

    btn_cnt_pulse dut (
        .clock (clock),
        .reset (reset),
        .btn   (btn),
        .cnt   (cnt),
        .level (level),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // cnt monitor: compare each pulse with the scoreboard and run a 4-bit downstream counter model
    always @(negedge clock) begin
        if (cnt === 1'b1) begin
            check("cnt_consec", {31'd0, prev_cnt}, 0);
            if (exp_q.size() == 0) check("cnt_spurious_cyc", cyc, -1);
            else check("cnt_at", cyc, exp_q.pop_front());
            pulse_n++;
            if (ctr4 == 15) begin
                co_cnt++;
                co_at = pulse_n;
            end
            ctr4 = (ctr4 + 1) % 16;
        end else if (cnt !== 1'b0) begin
            check("cnt_known", {31'd0, cnt}, 0);
        end
        prev_cnt = cnt;
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic press(output int p);
        btn = 1'b1;
        p = cyc + 1 + DB + 2;
        exp_q.push_back(p);
        wait_to(p - 1);
        check("pre_level", {31'd0, level}, 0);
        check("pre_busy", {31'd0, busy}, 1);
        wait_to(p);
        check("pulse_level", {31'd0, level}, 1);
        check("pulse_busy", {31'd0, busy}, 0);
    endtask

    task automatic release_check(input int p);
        int c;
        int r;
        c = cyc;
        btn = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        for (int t = p + RP + 1; t <= c + 2; t += RP + 1) exp_q.push_back(t);
`endif
        r = c + 1;
        wait_to(r + DB + 1);
        check("rel_level_hold", {31'd0, level}, 1);
        check("rel_busy", {31'd0, busy}, 1);
        wait_to(r + DB + 2);
        check("rel_level", {31'd0, level}, 0);
        check("rel_busy_off", {31'd0, busy}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int p;
        reset = 1'b1;
        btn = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("rst_cnt", {31'd0, cnt}, 0);
            check("rst_level", {31'd0, level}, 0);
            check("rst_busy", {31'd0, busy}, 0);
        end
        reset = 1'b0;
        press(p);
        wait_to(p + 3);
        release_check(p);

        wait_to(cyc + 3);
        press(p);
        wait_to(p + 30);
        release_check(p);

        wait_to(cyc + 3);
        for (int i = 0; i < 4; i++) begin
            btn = (i % 2 == 0);
            repeat (2) @(negedge clock);
        end
        press(p);
        wait_to(p + 5);
        release_check(p);

        wait_to(cyc + 3);
        press(p);
        wait_to(p + 5);
        btn = 1'b0;
        repeat (2) @(negedge clock);
        btn = 1'b1;
        wait_to(p + 11);
        check("glitch_level", {31'd0, level}, 1);
        check("glitch_busy", {31'd0, busy}, 0);
        release_check(p + 9);

        wait_to(cyc + 3);
        btn = 1'b1;
        repeat (4) @(negedge clock);
        check("mid_db_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        btn = 1'b0;
        @(negedge clock);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_level", {31'd0, level}, 0);
        reset = 1'b0;
        wait_to(cyc + 12);

        ctr4 = 0;
        co_cnt = 0;
        co_at = 0;
        pulse_n = 0;
        for (int i = 0; i < 17; i++) begin
            wait_to(cyc + 3);
            press(p);
            wait_to(p + 5);
            release_check(p);
        end
        check("ctr_out", ctr4, 1);
        check("co_count", co_cnt, 1);
        check("co_at", co_at, 16);

        wait_to(cyc + 3);
        pulse_n = 0;
        press(p);
        wait_to(p + 59);
        release_check(p);
        wait_to(cyc + 5);
        check("repeat_pulses", pulse_n, 1 + N_REP);

        wait_to(cyc + 5);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
